// File: rtl/nemo_spi_sequencer.sv
// nemo_spi_sequencer
// Sequencer that sits in front of the SPI monarch for the NEMO gyro. After
// power-up it waits for the sensor, issues three configuration writes and
// then turns every data-ready interrupt into a yaw-low/yaw-high read pair.
// The two bytes are assembled into a 16-bit yaw rate.

module nemo_spi_sequencer #(
    parameter int          INIT_WAIT_W   = 16,
    parameter logic [15:0] CFG_INT_CMD   = 16'h0D02,
    parameter logic [15:0] CFG_GYRO_CMD  = 16'h1160,
    parameter logic [15:0] CFG_ROUND_CMD = 16'h1440,
    parameter logic [15:0] RD_YAWL_CMD   = 16'hA600,
    parameter logic [15:0] RD_YAWH_CMD   = 16'hA700
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        setup_done,
    output logic [15:0] yaw_rt,
    output logic        vld
);

    typedef enum logic [2:0] {
        INIT_WAIT,
        CFG_INT,
        CFG_GYRO,
        CFG_ROUND,
        WAIT_INT,
        RD_YAWL,
        RD_YAWH
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   int_ff1;
    logic                   int_ff2;
    logic [INIT_WAIT_W-1:0] wait_cnt;
    logic [7:0]             yaw_lo;

    logic                   wrt_nxt;
    logic [15:0]            cmd_nxt;
    logic                   setup_nxt;
    logic                   vld_nxt;
    logic                   cap_lo;
    logic                   load_yaw;

    // Only the low byte of each read carries yaw data; the echo byte is dropped.
    logic                   unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:8];

    // Two-flop synchronizer for the asynchronous sensor interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1 <= 1'b0;
            int_ff2 <= 1'b0;
        end else begin
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
        end
    end

    // Power-up wait counter; runs only while waiting and rests at zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == INIT_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: every transaction-bound state advances only on done.
    always_comb begin
        next_state = state;
        case (state)
            INIT_WAIT: if (&wait_cnt) next_state = CFG_INT;
            CFG_INT:   if (done)      next_state = CFG_GYRO;
            CFG_GYRO:  if (done)      next_state = CFG_ROUND;
            CFG_ROUND: if (done)      next_state = WAIT_INT;
            WAIT_INT:  if (int_ff2)   next_state = RD_YAWL;
            RD_YAWL:   if (done)      next_state = RD_YAWH;
            RD_YAWH:   if (done)      next_state = WAIT_INT;
            default:                  next_state = INIT_WAIT;
        endcase
    end

    // Output decode: launches the next SPI word together with its start pulse.
    always_comb begin
        wrt_nxt   = 1'b0;
        cmd_nxt   = cmd;
        setup_nxt = setup_done;
        vld_nxt   = 1'b0;
        cap_lo    = 1'b0;
        load_yaw  = 1'b0;
        case (state)
            INIT_WAIT: begin
                if (&wait_cnt) begin
                    wrt_nxt = 1'b1;
                    cmd_nxt = CFG_INT_CMD;
                end
            end
            CFG_INT: begin
                if (done) begin
                    wrt_nxt = 1'b1;
                    cmd_nxt = CFG_GYRO_CMD;
                end
            end
            CFG_GYRO: begin
                if (done) begin
                    wrt_nxt = 1'b1;
                    cmd_nxt = CFG_ROUND_CMD;
                end
            end
            CFG_ROUND: begin
                if (done) setup_nxt = 1'b1;
            end
            WAIT_INT: begin
                if (int_ff2) begin
                    wrt_nxt = 1'b1;
                    cmd_nxt = RD_YAWL_CMD;
                end
            end
            RD_YAWL: begin
                if (done) begin
                    cap_lo  = 1'b1;
                    wrt_nxt = 1'b1;
                    cmd_nxt = RD_YAWH_CMD;
                end
            end
            RD_YAWH: begin
                if (done) begin
                    load_yaw = 1'b1;
                    vld_nxt  = 1'b1;
                end
            end
            default: begin
                wrt_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs and yaw assembly; yaw_rt only moves together with vld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrt        <= 1'b0;
            cmd        <= 16'h0000;
            setup_done <= 1'b0;
            vld        <= 1'b0;
            yaw_lo     <= 8'h00;
            yaw_rt     <= 16'h0000;
        end else begin
            wrt        <= wrt_nxt;
            cmd        <= cmd_nxt;
            setup_done <= setup_nxt;
            vld        <= vld_nxt;
            if (cap_lo)   yaw_lo <= rd_data[7:0];
            if (load_yaw) yaw_rt <= {rd_data[7:0], yaw_lo};
        end
    end

endmodule
